// File: rtl/param_pipe_barrel_shifter_if.sv
// Handshake bundle for param_pipe_barrel_shifter.
//   master : the producer/consumer side (drives in_*, out_ready)
//   slave  : the shifter itself (drives in_ready, out_*)
// Signals: in_valid/in_ready/in_data/in_amt/in_mode on the input side,
//          out_valid/out_ready/out_data (and out_carry) on the output side.
// Optional macro BPS_CARRY_EN adds out_carry; build the interface and the
// shifter with the same WIDTH and the same macro setting.
interface param_pipe_barrel_shifter_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef BPS_CARRY_EN
  logic             out_carry;
`endif

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data
`ifdef BPS_CARRY_EN
    , input out_carry
`endif
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data
`ifdef BPS_CARRY_EN
    , output out_carry
`endif
  );
endinterface

// File: rtl/param_pipe_barrel_shifter.sv
// Pipelined barrel shifter: shifts/rotates a WIDTH-bit word by a runtime
// amount in one of four modes (00 SLL, 01 SRL, 10 SRA, 11 ROR), using
// $clog2(WIDTH) registered stages; stage k shifts by 2**k when amt bit k is set.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, discards all in-flight words
//   bus    - param_pipe_barrel_shifter_if.slave: valid/ready input side
//            (in_data, in_amt, in_mode) and output side (out_data[, out_carry])
// Flow control: the whole pipe advances when the output is empty or taken;
// otherwise every stage holds (global stall). in_ready is that advance term.
// Optional macro BPS_CARRY_EN: adds out_carry, the last bit shifted out,
// tracked per stage and aligned with out_data.
module param_pipe_barrel_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  param_pipe_barrel_shifter_if.slave bus
);
  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned NSTG = SHW;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } bps_mode_e;

  logic adv;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int unsigned S = 2 ** k;

    logic             src_valid;
    logic             src_sh;
    logic [1:0]       src_mode;
    logic [WIDTH-1:0] src_data;
    logic [WIDTH-1:0] shf_data;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
`ifdef BPS_CARRY_EN
    logic             src_carry;
    logic             shf_carry;
    logic             carry_q;
`endif

    if (k == 0) begin : g_src
      assign src_valid = bus.in_valid;
      assign src_sh    = bus.in_amt[0];
      assign src_mode  = bus.in_mode;
      assign src_data  = bus.in_data;
`ifdef BPS_CARRY_EN
      assign src_carry = 1'b0;
`endif
    end else begin : g_src
      assign src_valid = g_stg[k-1].valid_q;
      assign src_sh    = g_stg[k-1].g_fwd.amt_q[k];
      assign src_mode  = g_stg[k-1].g_fwd.mode_q;
      assign src_data  = g_stg[k-1].data_q;
`ifdef BPS_CARRY_EN
      assign src_carry = g_stg[k-1].carry_q;
`endif
    end

    // Carry is the last bit pushed out by the most recent non-zero stage;
    // for ROR that bit is the one landing in the MSB.
    always_comb begin
      shf_data = src_data;
`ifdef BPS_CARRY_EN
      shf_carry = src_carry;
`endif
      if (src_sh) begin
        case (bps_mode_e'(src_mode))
          MODE_SLL: shf_data = src_data << S;
          MODE_SRL: shf_data = src_data >> S;
          MODE_SRA: shf_data = $signed(src_data) >>> S;
          default:  shf_data = (src_data >> S) | (src_data << (WIDTH - S));
        endcase
`ifdef BPS_CARRY_EN
        if (bps_mode_e'(src_mode) == MODE_SLL) shf_carry = src_data[WIDTH-S];
        else                                   shf_carry = src_data[S-1];
`endif
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
`ifdef BPS_CARRY_EN
        carry_q <= 1'b0;
`endif
      end else if (adv) begin
        valid_q <= src_valid;
        data_q  <= shf_data;
`ifdef BPS_CARRY_EN
        carry_q <= shf_carry;
`endif
      end
    end

    // Each stage forwards only the amount bits later stages still consume,
    // and the final stage needs neither amount nor mode.
    if (k < NSTG - 1) begin : g_fwd
      logic [SHW-1:k+1] nxt_amt;
      logic [SHW-1:k+1] amt_q;
      logic [1:0]       mode_q;

      if (k == 0) begin : g_amt
        assign nxt_amt = bus.in_amt[SHW-1:1];
      end else begin : g_amt
        assign nxt_amt = g_stg[k-1].g_fwd.amt_q[SHW-1:k+1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_q  <= '0;
          mode_q <= '0;
        end else if (adv) begin
          amt_q  <= nxt_amt;
          mode_q <= src_mode;
        end
      end
    end
  end

  always_comb begin
    adv           = !g_stg[NSTG-1].valid_q || bus.out_ready;
    bus.in_ready  = adv;
    bus.out_valid = g_stg[NSTG-1].valid_q;
    bus.out_data  = g_stg[NSTG-1].data_q;
`ifdef BPS_CARRY_EN
    bus.out_carry = g_stg[NSTG-1].carry_q;
`endif
  end
endmodule

// File: tb/tb_param_pipe_barrel_shifter.sv
module tb_param_pipe_barrel_shifter;
  localparam int unsigned W    = 8;
  localparam int unsigned SW   = 3;
  localparam int unsigned NSTG = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_pipe_barrel_shifter_if #(.WIDTH(W)) bus ();

  param_pipe_barrel_shifter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]    mode;
    logic [SW-1:0] amt;
    logic [W-1:0]  data;
    logic [W-1:0]  exp_data;
    logic          exp_carry;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
  } res_t;

  vec_t vecs [16];
  res_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bitwise reference: each result bit picked straight from the source word.
  function automatic res_t model(input logic [W-1:0] d, input logic [SW-1:0] amt_v,
                                 input logic [1:0] mode);
    res_t r;
    int unsigned a;
    a = int'(amt_v);
    r.data  = '0;
    r.carry = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      case (mode)
        2'd0: r.data[i] = (i >= int'(a)) ? d[SW'(i - int'(a))] : 1'b0;
        2'd1: r.data[i] = (i + int'(a) < int'(W)) ? d[SW'(i + int'(a))] : 1'b0;
        2'd2: r.data[i] = (i + int'(a) < int'(W)) ? d[SW'(i + int'(a))] : d[W-1];
        default: r.data[i] = d[SW'((i + int'(a)) % int'(W))];
      endcase
    end
    if (a != 0) begin
      if (mode == 2'd0)      r.carry = d[SW'(W - a)];
      else if (mode == 2'd3) r.carry = r.data[W-1];
      else                   r.carry = d[SW'(a - 1)];
    end
    return r;
  endfunction

  // Scoreboard: record accepted words, compare every output transfer in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_data, bus.in_amt, bus.in_mode));
      if (bus.out_valid && bus.out_ready) begin
        res_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got word %0h expected none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", 32'(bus.out_data), 32'(e.data));
`ifdef BPS_CARRY_EN
          check("sb_carry", 32'(bus.out_carry), 32'(e.carry));
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [SW-1:0] a,
                       input logic [1:0] m);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_mode  = m;
  endtask

  initial begin
    res_t  e0;
    vec_t  v;
    logic [W-1:0] wd [4];
    logic [SW-1:0] wa [4];
    logic [1:0]   wm [4];
    int unsigned  cyc;

    vecs[0]  = '{2'd0, 3'd3, 8'hB5, 8'hA8, 1'b1};
    vecs[1]  = '{2'd2, 3'd2, 8'h96, 8'hE5, 1'b1};
    vecs[2]  = '{2'd1, 3'd7, 8'h80, 8'h01, 1'b0};
    vecs[3]  = '{2'd3, 3'd1, 8'h81, 8'hC0, 1'b1};
    vecs[4]  = '{2'd0, 3'd0, 8'h5A, 8'h5A, 1'b0};
    vecs[5]  = '{2'd1, 3'd0, 8'h5A, 8'h5A, 1'b0};
    vecs[6]  = '{2'd2, 3'd0, 8'h5A, 8'h5A, 1'b0};
    vecs[7]  = '{2'd3, 3'd0, 8'h5A, 8'h5A, 1'b0};
    vecs[8]  = '{2'd0, 3'd7, 8'hFF, 8'h80, 1'b1};
    vecs[9]  = '{2'd2, 3'd7, 8'h7F, 8'h00, 1'b1};
    vecs[10] = '{2'd2, 3'd7, 8'h80, 8'hFF, 1'b0};
    vecs[11] = '{2'd3, 3'd7, 8'h01, 8'h02, 1'b0};
    vecs[12] = '{2'd1, 3'd4, 8'h3C, 8'h03, 1'b1};
    vecs[13] = '{2'd3, 3'd4, 8'h3C, 8'hC3, 1'b1};
    vecs[14] = '{2'd2, 3'd1, 8'h40, 8'h20, 1'b0};
    vecs[15] = '{2'd0, 3'd1, 8'h81, 8'h02, 1'b1};

    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    tick();

    // Directed table: one word at a time, exact latency of NSTG cycles
    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      drive(1'b1, v.data, v.amt, v.mode);
      tick();
      drive(1'b0, '0, '0, '0);
      tick();
      check("vec_not_early", 32'(bus.out_valid), 0);
      tick();
      check("vec_valid", 32'(bus.out_valid), 1);
      check("vec_data", 32'(bus.out_data), 32'(v.exp_data));
`ifdef BPS_CARRY_EN
      check("vec_carry", 32'(bus.out_carry), 32'(v.exp_carry));
`endif
      tick();
    end

    // Back-to-back stream of 16 random words
    for (int s = 0; s < 20; s++) begin
      if (s < 16)
        drive(1'b1, W'($urandom), SW'($urandom_range(W - 1)), 2'($urandom_range(3)));
      else
        drive(1'b0, '0, '0, '0);
      tick();
      check("stream_valid", 32'(bus.out_valid), ((s + 1 >= int'(NSTG)) && (s + 1 <= 18)) ? 1 : 0);
    end
    check("stream_drained", 32'(exp_q.size()), 0);

    // Stall: output held 5 cycles with a word waiting at the input
    for (int i = 0; i < 4; i++) begin
      wd[i] = W'($urandom);
      wa[i] = SW'(i + 3);
      wm[i] = 2'(i);
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, wd[i], wa[i], wm[i]);
      tick();
    end
    e0 = model(wd[0], wa[0], wm[0]);
    drive(1'b1, wd[3], wa[3], wm[3]);
    for (int c = 0; c < 5; c++) begin
      check("stall_in_ready", 32'(bus.in_ready), 0);
      check("stall_valid", 32'(bus.out_valid), 1);
      check("stall_data", 32'(bus.out_data), 32'(e0.data));
`ifdef BPS_CARRY_EN
      check("stall_carry", 32'(bus.out_carry), 32'(e0.carry));
`endif
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    drive(1'b0, '0, '0, '0);
    cyc = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && cyc < 20) begin
      tick();
      cyc++;
    end
    check("stall_drained", 32'(exp_q.size()), 0);
    check("stall_idle", 32'(bus.out_valid), 0);

    // Reset with words in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, wd[i], wa[i], wm[i]);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    check("pre_rst_valid", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 0);
    check("async_rst_data", 32'(bus.out_data), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("no_stale", 32'(bus.out_valid), 0);
    end
    drive(1'b1, 8'hB5, 3'd3, 2'd0);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    check("post_rst_not_early", 32'(bus.out_valid), 0);
    tick();
    check("post_rst_valid", 32'(bus.out_valid), 1);
    check("post_rst_data", 32'(bus.out_data), 32'h000000A8);
    tick();
    check("final_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
